seg_disp_scan_ctrl: RTL and testbench

Avalon-MM slave that owns a time-multiplexed bank of seven-segment digits and sequences them onto one shared segment bus. Software writes per-digit hex values and control settings. A prescaled scan sequencer drives one digit-select line at a time, with hex-to-segment decode, per-digit blanking and global blink. It sits between the Nios II data master and the board's segment/digit pins, replacing per-digit PIO ports.

---
 rtl/seg_disp_scan_ctrl_if.sv | 23 ++
 rtl/seg_disp_scan_ctrl.sv | 142 ++++++++++++++
 tb/tb_seg_disp_scan_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/seg_disp_scan_ctrl_if.sv
// Avalon-MM slave bus bundle for seg_disp_scan_ctrl.
//   address    : register word address (4 bits)
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : write data (32 bits)
//   readdata   : read data, combinational from address (read latency 0)
interface seg_disp_scan_ctrl_if;
  logic [3:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/seg_disp_scan_ctrl.sv
// Time-multiplexed seven-segment display controller with an Avalon-MM
// register file. A prescaled scan pointer selects one digit at a time; the
// digit's hex value is decoded onto a shared active-low segment bus, with
// per-digit blanking and an optional global blink.
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   avs      : Avalon-MM slave (DIGITk at 0..NUM_DIGITS-1, CTRL at 8,
//              PRESCALE at 9; everything else reads 0, writes ignored)
//   seg_n    : active-low segments, [0]=a .. [6]=g
//   dig_n    : active-low one-hot digit select
module seg_disp_scan_ctrl #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned PRESCALE_RST = 49999,
  parameter int unsigned BLINK_DIV    = 256
) (
  input  logic                  clk,
  input  logic                  reset_n,
  seg_disp_scan_ctrl_if.slave   avs,
  output logic [6:0]            seg_n,
  output logic [NUM_DIGITS-1:0] dig_n
);

  localparam int unsigned PW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [4:0]            digit_q [NUM_DIGITS];
  logic [4:0]            digit_d [NUM_DIGITS];
  logic [1:0]            ctrl_q, ctrl_d;
  logic [15:0]           prescale_q, prescale_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic [BW-1:0]         bcnt_q, bcnt_d;
  logic                  bph_q, bph_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] dig_q, dig_d;

  logic                  we;
  logic                  enable;
  logic                  tick;
  logic [4:0]            cur;
  logic [NUM_DIGITS-1:0] onehot;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign we     = avs.chipselect && !avs.write_n;
  assign enable = ctrl_q[0];
  assign tick   = enable && (cnt_q == '0);

  // Register writes
  always_comb begin
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      digit_d[k] = digit_q[k];
      if (we && avs.address == 4'(k)) digit_d[k] = avs.writedata[4:0];
    end
    ctrl_d     = ctrl_q;
    prescale_d = prescale_q;
    if (we && avs.address == 4'd8) ctrl_d     = avs.writedata[1:0];
    if (we && avs.address == 4'd9) prescale_d = avs.writedata[15:0];
  end

  // Zero-latency read mux
  always_comb begin
    avs.readdata = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (avs.address == 4'(k)) avs.readdata = {27'd0, digit_q[k]};
    end
    if (avs.address == 4'd8) avs.readdata = {30'd0, ctrl_q};
    if (avs.address == 4'd9) avs.readdata = {16'd0, prescale_q};
  end

  // Scan sequencer and output register. Outputs are built from the
  // current ptr_q, so they trail a ptr change by exactly one edge and the
  // digit/segment pair always moves together.
  always_comb begin
    cnt_d  = cnt_q;
    ptr_d  = ptr_q;
    bcnt_d = bcnt_q;
    bph_d  = bph_q;
    seg_d  = '1;
    dig_d  = '1;
    onehot = '0;
    cur    = digit_q[ptr_q];
    if (!enable) begin
      cnt_d  = prescale_q;
      ptr_d  = '0;
      bcnt_d = '0;
      bph_d  = 1'b0;
    end else begin
      cnt_d = tick ? prescale_q : cnt_q - 16'd1;
      if (tick) begin
        ptr_d = (ptr_q == PW'(NUM_DIGITS - 1)) ? '0 : ptr_q + 1'b1;
        if (bcnt_q == BW'(BLINK_DIV - 1)) begin
          bcnt_d = '0;
          bph_d  = ~bph_q;
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
      onehot[ptr_q] = 1'b1;
      dig_d         = ~onehot;
      if (cur[4] || (ctrl_q[1] && bph_q)) seg_d = '1;
      else                                seg_d = hex7(cur[3:0]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned k = 0; k < NUM_DIGITS; k++) digit_q[k] <= '0;
      ctrl_q     <= '0;
      prescale_q <= 16'(PRESCALE_RST);
      cnt_q      <= 16'(PRESCALE_RST);
      ptr_q      <= '0;
      bcnt_q     <= '0;
      bph_q      <= 1'b0;
      seg_q      <= 7'h7F;
      dig_q      <= '1;
    end else begin
      for (int unsigned k = 0; k < NUM_DIGITS; k++) digit_q[k] <= digit_d[k];
      ctrl_q     <= ctrl_d;
      prescale_q <= prescale_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      bcnt_q     <= bcnt_d;
      bph_q      <= bph_d;
      seg_q      <= seg_d;
      dig_q      <= dig_d;
    end
  end

  assign seg_n = seg_q;
  assign dig_n = dig_q;

endmodule

// File: tb/tb_seg_disp_scan_ctrl.sv
// Directed self-checking bench for seg_disp_scan_ctrl (4 digits, BLINK_DIV=2).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_seg_disp_scan_ctrl;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] seg_n;
  logic [3:0] dig_n;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Expected dig_n per ptr and segments for digits 1,2,3,4 / 1,2,A,4
  logic [3:0] dig_t  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  logic [6:0] seg_a  [4] = '{7'h79, 7'h24, 7'h30, 7'h19};
  logic [6:0] seg_b  [4] = '{7'h79, 7'h24, 7'h08, 7'h19};

  seg_disp_scan_ctrl_if bus ();

  seg_disp_scan_ctrl #(
    .NUM_DIGITS  (4),
    .PRESCALE_RST(49999),
    .BLINK_DIV   (2)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .avs    (bus),
    .seg_n  (seg_n),
    .dig_n  (dig_n)
  );

  always #5 clk = ~clk;

  // Called at a falling edge; the write lands on the next rising edge and
  // the task returns at the falling edge after it.
  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.writedata  = d;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic test_reset(input string tag);
    logic [31:0] exp;
    n_cmp++;
    if (seg_n !== 7'h7F) begin
      n_err++; $display("FAIL %s_seg got %h expected 7f", tag, seg_n);
    end
    n_cmp++;
    if (dig_n !== 4'hF) begin
      n_err++; $display("FAIL %s_dig got %h expected f", tag, dig_n);
    end
    for (int a = 0; a < 16; a++) begin
      bus.address = 4'(a);
      #1;
      exp = (a == 9) ? 32'h0000C34F : 32'h0;
      n_cmp++;
      if (bus.readdata !== exp) begin
        n_err++; $display("FAIL %s_read addr=%0d got %h expected %h", tag, a, bus.readdata, exp);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_regs;
    logic [31:0] exp;
    for (int a = 4; a < 8; a++) bus_write(4'(a), 32'hFFFFFFFF);
    for (int a = 10; a < 16; a++) bus_write(4'(a), 32'hFFFFFFFF);
    bus_write(4'd0, 32'hFFFFFFFF);
    bus_write(4'd9, 32'hFFFFFFFF);
    bus_write(4'd8, 32'hFFFFFFFC);
    for (int a = 0; a < 16; a++) begin
      bus.address = 4'(a);
      #1;
      exp = (a == 0) ? 32'h1F : (a == 9) ? 32'hFFFF : 32'h0;
      n_cmp++;
      if (bus.readdata !== exp) begin
        n_err++; $display("FAIL regs_read addr=%0d got %h expected %h", a, bus.readdata, exp);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (dig_n !== 4'hF) begin
      n_err++; $display("FAIL regs_idle_dig got %h expected f", dig_n);
    end
  endtask

  task automatic test_scan;
    int p;
    bus_write(4'd0, 32'd1);
    bus_write(4'd1, 32'd2);
    bus_write(4'd2, 32'd3);
    bus_write(4'd3, 32'd4);
    bus_write(4'd9, 32'd3);
    bus_write(4'd8, 32'd1);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      p = ((k - 1) / 4) % 4;
      n_cmp++;
      if (dig_n !== dig_t[p]) begin
        n_err++; $display("FAIL scan_dig k=%0d got %h expected %h", k, dig_n, dig_t[p]);
      end
      n_cmp++;
      if (seg_n !== seg_a[p]) begin
        n_err++; $display("FAIL scan_seg k=%0d got %h expected %h", k, seg_n, seg_a[p]);
      end
    end
  endtask

  task automatic test_blank;
    bus_write(4'd8, 32'd0);
    bus_write(4'd2, 32'h1A);
    bus.address = 4'd2;
    #1;
    n_cmp++;
    if (bus.readdata !== 32'h1A) begin
      n_err++; $display("FAIL blank_read got %h expected 1a", bus.readdata);
    end
    @(negedge clk);
    bus_write(4'd8, 32'd1);
    repeat (8) @(negedge clk);
    for (int k = 9; k <= 12; k++) begin
      @(negedge clk);
      n_cmp++;
      if (dig_n !== 4'hB || seg_n !== 7'h7F) begin
        n_err++; $display("FAIL blank_slot k=%0d got dig=%h seg=%h expected dig=b seg=7f", k, dig_n, seg_n);
      end
    end
    bus_write(4'd8, 32'd0);
    bus_write(4'd2, 32'h0A);
    bus_write(4'd8, 32'd1);
    repeat (9) @(negedge clk);
    n_cmp++;
    if (dig_n !== 4'hB || seg_n !== 7'h08) begin
      n_err++; $display("FAIL unblank_slot got dig=%h seg=%h expected dig=b seg=08", dig_n, seg_n);
    end
  endtask

  task automatic test_blink;
    int p;
    logic [6:0] exp;
    bus_write(4'd8, 32'd0);
    bus_write(4'd9, 32'd0);
    bus_write(4'd8, 32'd3);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      p   = (k - 1) % 4;
      exp = (((k - 1) / 2) % 2 == 1) ? 7'h7F : seg_b[p];
      n_cmp++;
      if (dig_n !== dig_t[p]) begin
        n_err++; $display("FAIL blink_dig k=%0d got %h expected %h", k, dig_n, dig_t[p]);
      end
      n_cmp++;
      if (seg_n !== exp) begin
        n_err++; $display("FAIL blink_seg k=%0d got %h expected %h", k, seg_n, exp);
      end
    end
  endtask

  task automatic test_disable_midscan;
    bus_write(4'd8, 32'd0);
    bus_write(4'd9, 32'd3);
    bus_write(4'd8, 32'd1);
    repeat (9) @(negedge clk);
    n_cmp++;
    if (dig_n !== 4'hB || seg_n !== 7'h08) begin
      n_err++; $display("FAIL midscan_ptr2 got dig=%h seg=%h expected dig=b seg=08", dig_n, seg_n);
    end
    bus_write(4'd8, 32'd0);
    n_cmp++;
    if (dig_n !== 4'hB) begin
      n_err++; $display("FAIL midscan_write_edge_dig got %h expected b", dig_n);
    end
    @(negedge clk);
    n_cmp++;
    if (dig_n !== 4'hF || seg_n !== 7'h7F) begin
      n_err++; $display("FAIL midscan_off got dig=%h seg=%h expected dig=f seg=7f", dig_n, seg_n);
    end
    repeat (5) @(negedge clk);
    n_cmp++;
    if (dig_n !== 4'hF || seg_n !== 7'h7F) begin
      n_err++; $display("FAIL midscan_stay_off got dig=%h seg=%h expected dig=f seg=7f", dig_n, seg_n);
    end
    bus_write(4'd8, 32'd1);
    @(negedge clk);
    n_cmp++;
    if (dig_n !== 4'hE || seg_n !== 7'h79) begin
      n_err++; $display("FAIL reenable got dig=%h seg=%h expected dig=e seg=79", dig_n, seg_n);
    end
  endtask

  task automatic test_async_reset;
    repeat (6) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if (dig_n !== 4'hF || seg_n !== 7'h7F) begin
      n_err++; $display("FAIL async_reset_now got dig=%h seg=%h expected dig=f seg=7f", dig_n, seg_n);
    end
    #10 reset_n = 1'b1;
    @(negedge clk);
    test_reset("post_reset");
    repeat (3) @(negedge clk);
    n_cmp++;
    if (dig_n !== 4'hF) begin
      n_err++; $display("FAIL post_reset_idle_dig got %h expected f", dig_n);
    end
  endtask

  initial begin
    bus.address    = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    reset_n        = 1'b0;
    #22 reset_n = 1'b1;
    @(negedge clk);
    test_reset("reset");
    test_regs();
    test_scan();
    test_blank();
    test_blink();
    test_disable_midscan();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
